// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the M stage (master) and the data memory (slave).
// The request fields are held stable while dm_req is high.
// dm_ack is a single-cycle completion strobe that qualifies dm_rdata.
interface mem_access_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [3:0]            dm_be;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: word/byte loads and stores over a req/ack bus, drives MEM/WB.
// Latency: 1 edge for non-memory ops, 2+N edges for accesses (N = REQ cycles).
// Backpressure: StallM freezes upstream from presentation until DONE; MEM_TIMEOUT_EN adds a REQ watchdog.
module mem_access_stage #(
  parameter int DATA_WIDTH     = 32,  // byte-lane logic assumes exactly 4 lanes
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic                  StSrcM,
  input  logic                  LdSrcM,
  input  logic [1:0]            ResultSrcM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [DATA_WIDTH-1:0] PC_PlusM,
  input  logic [4:0]            RdM,
  mem_access_stage_if.master    dm,
  output logic                  StallM,
  output logic                  MemErr,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [DATA_WIDTH-1:0] PC_PlusW,
  output logic [4:0]            RdW
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state_q, state_d;
  logic   stall;

  logic   access, start, ack_hit;
  logic   to_hit, to_q;

  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic [1:0]            off_q;
  logic                  ld_byte_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign access  = MemWriteM | (ResultSrcM == 2'b01);
  assign start   = (state_q == IDLE) && access;
  // An ack is only meaningful while the request is outstanding.
  assign ack_hit = (state_q == REQ) && dm.dm_ack;

  // State register; reset drops REQ (and hence dm_req) immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and stall decode.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dm.dm_ack || to_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign StallM    = stall & ~rst;
  assign dm.dm_req = (state_q == REQ);
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign dm.dm_be    = be_q;

  // Latch the bus request when an access leaves IDLE; held stable through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= 4'b0000;
      off_q     <= 2'b00;
      ld_byte_q <= 1'b0;
    end else if (start) begin
      we_q      <= MemWriteM;
      addr_q    <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
      off_q     <= ALUResultM[1:0];
      ld_byte_q <= LdSrcM;
      if (MemWriteM && StSrcM) begin
        // Byte store: replicate the byte on all lanes, enable only the addressed one.
        be_q    <= 4'b0001 << ALUResultM[1:0];
        wdata_q <= {4{WriteDataM[7:0]}};
      end else begin
        be_q    <= 4'b1111;
        wdata_q <= MemWriteM ? WriteDataM : '0;
      end
    end
  end

  // Capture formatted read data on ack; writes and aborted accesses leave zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (start) begin
      rdata_q <= '0;
    end else if (ack_hit && !we_q) begin
      if (ld_byte_q) rdata_q <= {{(DATA_WIDTH-8){1'b0}}, dm.dm_rdata[{off_q, 3'b000} +: 8]};
      else           rdata_q <= dm.dm_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;

  // Final unacknowledged REQ cycle; a same-cycle ack takes precedence.
  assign to_hit = (state_q == REQ) && !dm.dm_ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts unacknowledged REQ cycles, remembers an abort, pulses MemErr in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
      MemErr <= 1'b0;
    end else begin
      MemErr <= to_hit;
      if (start) begin
        to_cnt <= '0;
        to_q   <= 1'b0;
      end else if ((state_q == REQ) && !dm.dm_ack) begin
        to_cnt <= to_cnt + 1'b1;
        to_q   <= to_hit;
      end
    end
  end
`else
  assign to_hit = 1'b0;
  assign to_q   = 1'b0;
  assign MemErr = 1'b0;
`endif

  // MEM/WB register: pass-through in IDLE, bubble on access start, load result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PC_PlusW   <= '0;
      RdW        <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            RegWriteW <= 1'b0;
          end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= '0;
            PC_PlusW   <= PC_PlusM;
            RdW        <= RdM;
          end
        end
        DONE: begin
          RegWriteW  <= RegWriteM & ~to_q;
          ResultSrcW <= ResultSrcM;
          ALUResultW <= ALUResultM;
          ReadDataW  <= rdata_q;
          PC_PlusW   <= PC_PlusM;
          RdW        <= RdM;
        end
        default: ;
      endcase
    end
  end

endmodule
